// File: rtl/wdt.sv
// Watchdog timer: counts edges after enable or kick and raises a registered timeout
// once the count has sat at the programmed limit for one more edge.
module wdt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [1:0]       waddr,
  input  logic [CNT_W-1:0] wdata,
  input  logic [1:0]       raddr,
  output logic [CNT_W-1:0] rdata,
  output logic             timeout
);

  typedef enum logic [1:0] {StIdle, StCount, StTimeout} state_e;

  state_e           state_q;
  logic             wden_q;
  logic [CNT_W-1:0] wtocnt_q;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;

  logic wr_wden, wr_wto, kick, arm, disarm;

  assign wr_wden = wen && (waddr == 2'b00);
  assign wr_wto  = wen && (waddr == 2'b10);
  assign kick    = wen && (waddr == 2'b01) && wdata[0];
  assign arm     = wr_wden && wdata[0];
  assign disarm  = wr_wden && !wdata[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      wden_q    <= 1'b0;
      wtocnt_q  <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (wr_wden) wden_q <= wdata[0];
      // The limit is frozen while the watchdog is armed.
      if (wr_wto && !wden_q) wtocnt_q <= wdata;

      if (disarm) begin
        state_q   <= StIdle;
        cnt_q     <= '0;
        timeout_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (arm) begin
              state_q <= StCount;
              cnt_q   <= '0;
            end
          end
          StCount: begin
            if (kick) begin
              cnt_q <= '0;
            end else if (cnt_q == wtocnt_q) begin
              // Equality is always reached before wrap, so cnt never overflows.
              state_q   <= StTimeout;
              timeout_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StTimeout: begin
            if (kick) begin
              state_q   <= StCount;
              cnt_q     <= '0;
              timeout_q <= 1'b0;
            end
          end
          default: begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    unique case (raddr)
      2'b00:   rdata = {{(CNT_W-1){1'b0}}, wden_q};
      2'b01:   rdata = '0;
      2'b10:   rdata = wtocnt_q;
      2'b11:   rdata = cnt_q;
      default: rdata = '0;
    endcase
  end

  assign timeout = timeout_q;

endmodule
